gate_unit_arbiter: RTL



---
 rtl/gate_unit_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//
// Round-robin front end for a shared, registered multi-function gate unit.
// One request is accepted at a time. It is evaluated one cycle later, and
// the result is returned with the id of the requester that was served.
// The response channel uses a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid             [NUM_REQ]
//   req_ready  one-hot combinational accept strobe      [NUM_REQ]
//   req_op     opcodes, requester i at [3i+:3]          [3*NUM_REQ]
//   req_a      operand A, requester i at [WIDTH*i+:W]   [WIDTH*NUM_REQ]
//   req_b      operand B, same packing as req_a         [WIDTH*NUM_REQ]
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     index of the served requester            [ID_W]
//   rsp_data   gate result                              [WIDTH]
//   busy       high while a request is in flight (EXEC or RESP)
//   op_count   saturating count of completed responses  [16]
//              (present only when GATE_ARB_OPCNT_EN is defined)
//
// Opcodes: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF a.
//
// Optional feature macro: GATE_ARB_OPCNT_EN

module gate_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
`ifdef GATE_ARB_OPCNT_EN
  output logic                     busy,
  output logic [15:0]              op_count
`else
  output logic                     busy
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  data_q;

  logic              grantFound;
  logic [ID_W-1:0]   grantIdx;
  logic [ID_W:0]     scanSum;
  logic              handshake;

  logic [2:0]        opArr [NUM_REQ];
  logic [WIDTH-1:0]  aArr  [NUM_REQ];
  logic [WIDTH-1:0]  bArr  [NUM_REQ];

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      opArr[i] = req_op[3*i +: 3];
      aArr[i]  = req_a[WIDTH*i +: WIDTH];
      bArr[i]  = req_b[WIDTH*i +: WIDTH];
    end
  end

  // Round-robin scan: the first valid requester at or above ptr wins,
  // wrapping from NUM_REQ-1 back to 0. ptr + i never exceeds 2*NUM_REQ-2,
  // so one subtraction brings it back into range.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    scanSum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scanSum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scanSum >= (ID_W+1)'(NUM_REQ)) begin
        scanSum = scanSum - (ID_W+1)'(NUM_REQ);
      end
      if (!grantFound && req_valid[scanSum[ID_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = scanSum[ID_W-1:0];
      end
    end
  end

  // The accept strobe is only offered in IDLE. It is held low while reset
  // is asserted, so a requester cannot see an acceptance that is discarded.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  assign handshake = (state_q == RESP) && rsp_ready;

  // Next-state logic. After a response handshake, the pointer moves one
  // past the requester just served, giving that requester the lowest
  // priority on the next arbitration.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (grantFound) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (id_q == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + ID_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The gate function. Operand b is unused by NOT and BUF.
  function automatic logic [WIDTH-1:0] gateEval(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    unique case (op)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a ^ b;
      3'd6:    r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  // State, pointer and datapath registers. The request is captured on the
  // accept edge and evaluated in EXEC. A reset clears the result register,
  // so an in-flight result is never presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == IDLE && grantFound) begin
        id_q <= grantIdx;
        op_q <= opArr[grantIdx];
        a_q  <= aArr[grantIdx];
        b_q  <= bArr[grantIdx];
      end
      if (state_q == EXEC) begin
        data_q <= gateEval(op_q, a_q, b_q);
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != IDLE);

`ifdef GATE_ARB_OPCNT_EN
  logic [15:0] opCount_q;

  // Completed-response counter. It saturates at all-ones instead of
  // wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opCount_q <= '0;
    end else if (handshake && opCount_q != 16'hFFFF) begin
      opCount_q <= opCount_q + 16'd1;
    end
  end

  assign op_count = opCount_q;
`else
  logic unusedHandshake;
  assign unusedHandshake = handshake;
`endif

endmodule
